// File: rtl/system_id_regs.sv
// System-identification and housekeeping Avalon-MM slave: build ID, timestamp,
// free-running uptime counter with coherent 2-word readback, control and scratch words.
module system_id_regs #(
    parameter logic [31:0]       SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0]       TIMESTAMP    = 32'd1454761040,
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 3,
    parameter int                NUM_SCRATCH  = 2,
    parameter logic [DATA_W-1:0] SCRATCH_INIT = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam int IDX_W = (SCR_N > 1) ? $clog2(SCR_N) : 1;

    localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_HI   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(4);

    logic [2*DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                freeze_q, freeze_d;
    logic                rvalid_q;
    logic [DATA_W-1:0]   scratch_q [SCR_N];
    logic [DATA_W-1:0]   scratch_d [SCR_N];

    logic             rd_en;
    logic             ctrl_we;
    logic             clear;
    logic             scr_hit;
    logic [IDX_W-1:0] scr_idx;

    // A simultaneous read+write is a write only, so it never produces readdatavalid.
    assign rd_en   = read & ~write;
    assign ctrl_we = write && (address == A_CTRL) && byteenable[0];
    assign clear   = ctrl_we & writedata[0];
    assign scr_hit = ({1'b0, address} >= (ADDR_W+1)'(5)) &&
                     ({1'b0, address} <  (ADDR_W+1)'(5 + NUM_SCRATCH));
    assign scr_idx = IDX_W'(address - ADDR_W'(5));

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!freeze_q) begin
            cnt_d = cnt_q + (2*DATA_W)'(1);
        end
    end

    // FREEZE is sampled from the register, so a new value only gates the following edge.
    assign freeze_d = ctrl_we ? writedata[1] : freeze_q;
    assign shadow_d = (rd_en && address == A_LO) ? cnt_q[2*DATA_W-1:DATA_W] : shadow_q;

    always_comb begin
        scratch_d = scratch_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (write && address == ADDR_W'(5 + i)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (byteenable[b]) begin
                        scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            A_ID:    rdata_d = DATA_W'(SYSTEM_ID);
            A_TS:    rdata_d = DATA_W'(TIMESTAMP);
            A_LO:    rdata_d = cnt_q[DATA_W-1:0];
            A_HI:    rdata_d = shadow_q;
            A_CTRL:  rdata_d = DATA_W'({freeze_q, 1'b0});
            default: if (scr_hit) rdata_d = scratch_q[scr_idx];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            freeze_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            // NOTE: the scratch bank is a handful of flops that must come up at SCRATCH_INIT, so every entry is reset.
            for (int i = 0; i < SCR_N; i++) begin
                scratch_q[i] <= SCRATCH_INIT;
            end
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            freeze_q <= freeze_d;
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
            for (int i = 0; i < SCR_N; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_system_id_regs.sv
// Self-checking bench for system_id_regs: directed vector table, multi-cycle corner
// sequences, randomized traffic against a register-map model, and a 16-bit carry check.
module tb_system_id_regs;

    localparam logic [31:0] SYS_ID = 32'hA5A5_0001;
    localparam logic [31:0] TS     = 32'd1454761040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    logic [2:0]  a16 = '0;
    logic        rd16 = 1'b0;
    logic        wr16 = 1'b0;
    logic [15:0] wd16 = '0;
    logic [1:0]  be16 = '0;
    logic [15:0] q16;
    logic        v16;

    system_id_regs #(.SYSTEM_ID(SYS_ID)) dut (
        .clock(clk), .reset(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    system_id_regs #(.DATA_W(16)) dut16 (
        .clock(clk), .reset(rst), .address(a16), .read(rd16), .write(wr16),
        .writedata(wd16), .byteenable(be16),
        .readdata(q16), .readdatavalid(v16)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          exp_rv;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model of the register map, advanced once per clock edge.
    longint unsigned m_cnt;
    bit              m_freeze;
    logic [31:0]     m_shadow;
    logic [31:0]     m_scr [2];
    logic [31:0]     m_rdata;
    bit              m_rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_freeze = 1'b0;
        m_shadow = '0;
        m_scr[0] = '0;
        m_scr[1] = '0;
        m_rdata  = '0;
        m_rv     = 1'b0;
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [2:0] addr,
                              input logic [31:0] wd, input logic [3:0] be);
        bit clr = 1'b0;
        bit fz  = m_freeze;
        int idx = int'(addr) - 5;
        m_rv = rd && !wr;
        if (m_rv) begin
            case (addr)
                3'd0:    m_rdata = SYS_ID;
                3'd1:    m_rdata = TS;
                3'd2:    begin m_rdata = 32'(m_cnt); m_shadow = 32'(m_cnt >> 32); end
                3'd3:    m_rdata = m_shadow;
                3'd4:    m_rdata = {30'b0, m_freeze, 1'b0};
                3'd5,
                3'd6:    m_rdata = m_scr[idx];
                default: m_rdata = '0;
            endcase
        end
        if (wr) begin
            if (addr == 3'd4 && be[0]) begin
                clr = wd[0];
                fz  = wd[1];
            end
            if (addr == 3'd5 || addr == 3'd6) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) m_scr[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        if (clr)            m_cnt = 0;
        else if (!m_freeze) m_cnt = m_cnt + 1;
        m_freeze = fz;
    endtask

    // Entered and left at a falling edge; outputs of the transfer are visible on return.
    task automatic drive(input bit rd, input bit wr, input logic [2:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        read = rd; write = wr; address = addr; writedata = wd; byteenable = be;
        @(posedge clk);
        model_step(rd, wr, addr, wd, be);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic read_model(input string name, input logic [2:0] addr);
        drive(1'b1, 1'b0, addr, 32'h0, 4'h0);
        check({name, "_rv"}, 64'(readdatavalid), 64'(m_rv));
        check(name, 64'(readdata), 64'(m_rdata));
    endtask

    initial begin
        logic [31:0] lo_first;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rdata", 64'(readdata), 64'h0);
        check("reset_rv", 64'(readdatavalid), 64'h0);
        rst = 1'b0;

        // Directed table: identification words, scratch lane masking, RO writes, read+write, unmapped
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 1'b1, SYS_ID,        "id"});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0,         4'h0, 1'b1, TS,            "timestamp"});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h1234_5678, 4'h5, 1'b0, TS,            "wr_holds"});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0,         4'h0, 1'b1, 32'h0034_0078, "scratch0_masked"});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 32'h0,         4'h0, 1'b1, 32'h0,         "scratch1_untouched"});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         "wr_id"});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 1'b1, SYS_ID,        "id_ro"});
        vecs.push_back('{1'b1, 1'b1, 3'd6, 32'hDEAD_BEEF, 4'hF, 1'b0, SYS_ID,        "rdwr_no_rv"});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, "scratch1_rdwr"});
        vecs.push_back('{1'b1, 1'b0, 3'd7, 32'h0,         4'h0, 1'b1, 32'h0,         "unmapped_rd"});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         "unmapped_wr"});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 1'b1, 32'h0,         "ctrl_reset"});
        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be);
            check({vecs[i].name, "_rv"}, 64'(readdatavalid), 64'(vecs[i].exp_rv));
            check(vecs[i].name, 64'(readdata), 64'(vecs[i].exp_data));
        end

        // FREEZE holds the counter; CLEAR wins over FREEZE; FREEZE release lags one edge
        drive(1'b0, 1'b1, 3'd4, 32'h2, 4'h1);
        read_model("frz_lo1", 3'd2);
        lo_first = readdata;
        idle(9);
        read_model("frz_lo2", 3'd2);
        check("frz_equal", 64'(readdata), 64'(lo_first));
        drive(1'b0, 1'b1, 3'd4, 32'h3, 4'h1);
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        check("clr_frozen_lo", 64'(readdata), 64'h0);
        drive(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        check("ctrl_readback", 64'(readdata), 64'h2);
        drive(1'b0, 1'b1, 3'd4, 32'h0, 4'h1);
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        check("unfreeze_lag", 64'(readdata), 64'h0);
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        check("resume_count", 64'(readdata), 64'h1);
        drive(1'b0, 1'b1, 3'd4, 32'h3, 4'hE);
        read_model("ctrl_lane_gated", 3'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
            check("rand_rv", 64'(readdatavalid), 64'(m_rv));
            check("rand_rdata", 64'(readdata), 64'(m_rdata));
        end

        // Reset one cycle after a read strobe abandons readdatavalid and restores state
        drive(1'b0, 1'b1, 3'd4, 32'h2, 4'h1);
        drive(1'b0, 1'b1, 3'd5, 32'hCAFE_F00D, 4'hF);
        read = 1'b1; address = 3'd5;
        @(posedge clk);
        #1 rst = 1'b1;
        read = 1'b0;
        #1;
        check("rst_abort_rv", 64'(readdatavalid), 64'h0);
        check("rst_abort_rdata", 64'(readdata), 64'h0);
        @(negedge clk);
        check("rst_hold_rv", 64'(readdatavalid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        read_model("post_rst_scratch0", 3'd5);
        read_model("post_rst_lo", 3'd2);
        read_model("post_rst_hi", 3'd3);
        read_model("post_rst_ctrl", 3'd4);
        read_model("post_rst_lo_runs", 3'd2);

        // Carry coherence on the 16-bit instance: clear, then read LO exactly at 16'hFFFF
        wr16 = 1'b1; a16 = 3'd4; wd16 = 16'h1; be16 = 2'b01;
        @(posedge clk);
        @(negedge clk);
        wr16 = 1'b0;
        repeat (65535) @(negedge clk);
        rd16 = 1'b1; a16 = 3'd2;
        @(negedge clk);
        check("carry_lo_rv", 64'(v16), 64'h1);
        check("carry_lo", 64'(q16), 64'hFFFF);
        a16 = 3'd3;
        @(negedge clk);
        check("carry_hi", 64'(q16), 64'h0);
        a16 = 3'd2;
        @(negedge clk);
        check("after_carry_lo", 64'(q16), 64'h0001);
        a16 = 3'd3;
        @(negedge clk);
        rd16 = 1'b0;
        check("after_carry_hi", 64'(q16), 64'h0001);
        @(negedge clk);
        check("carry_rv_drop", 64'(v16), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/system_id_regs.md
# system_id_regs

Parametrised system-identification and housekeeping slave for the Nios II system's Avalon-MM interconnect, the next generation of the fixed two-word sysid peripheral. It adds a registered read path with `readdatavalid`, a free-running uptime counter with atomic 2-word readback, a control register, and a configurable bank of read/write scratch registers. Software uses it to:

- confirm the hardware build (ID, timestamp);
- measure elapsed time;
- leave breadcrumbs across soft resets.

## Interface
Parameters:
- SYSTEM_ID, 32'h0000_0000, build ID returned at word 0; truncated to DATA_W.
- TIMESTAMP, 32'd1454761040, generation timestamp returned at word 1; truncated to DATA_W.
- DATA_W, 32, data width; multiple of 8, 16..64.
- ADDR_W, 3, word-address width; 5+NUM_SCRATCH ≤ 2^ADDR_W required.
- NUM_SCRATCH, 2, number of R/W scratch registers, 0..16.
- SCRATCH_INIT, 0, reset value of every scratch register.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per transfer.
- write  in  1  write strobe, one cycle per transfer.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  byte lanes for writes; ignored on reads.
- readdata  out  DATA_W  registered read data.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.

## Operation
Register map (word addresses):
- 0 ID (RO): SYSTEM_ID.
- 1 TIMESTAMP (RO): TIMESTAMP.
- 2 UPTIME_LO (RO):
  - returns the low DATA_W bits of the counter;
  - in the same edge, latches the high DATA_W bits into the shadow register.
- 3 UPTIME_HI (RO): returns the shadow register, never the live high half.
- 4 CONTROL (RW):
  - bit0 CLEAR: write-1 pulse, self-clearing, reads 0;
  - bit1 FREEZE: level; when set, the counter holds;
  - other bits read 0.
- 5..4+NUM_SCRATCH SCRATCH[n] (RW): full DATA_W storage, byte-lane masked by byteenable.
- Any other address: reads 0, writes ignored; readdatavalid still pulses.

Uptime counter:
- Width 2·DATA_W; increments by 1 every clock while FREEZE=0.
- Wraps from all-ones to 0 with no flag.

Access rules:
- Writes to RO words are ignored.
- A CONTROL write applies only the byte lanes enabled; byteenable[0] gates CLEAR and FREEZE.
- Priority within a cycle: CLEAR > FREEZE > increment.
  - A CLEAR write forces the counter to 0 at that edge, regardless of FREEZE.
  - Counting resumes the next cycle if FREEZE=0.
  - CLEAR does not modify the shadow register.
- read and write asserted together: treated as a write only; no readdatavalid.

Reset state:
- Counter 0, shadow 0, FREEZE 0.
- All scratch registers = SCRATCH_INIT.
- readdata 0, readdatavalid 0.
- Reset asserted mid-transfer abandons any pending readdatavalid.

## Timing
- Fixed read latency 1. read is sampled at edge k; readdata and readdatavalid are valid during cycle k+1.
- readdatavalid is high for exactly one cycle per accepted read.
- readdata holds its last value when readdatavalid=0.
- Back-to-back reads on consecutive cycles are supported at full throughput; there is no waitrequest.
- The UPTIME_LO value returned is the counter value present before edge k; the shadow takes the matching high half at edge k.
- A write at edge k is visible to a read sampled at edge k+1.
- A FREEZE write takes effect from edge k+1: the counter still updates at edge k per its prior state.

## Test plan
1. Reset release, read words 0 and 1 (SYSTEM_ID=32'hA5A5_0001) → readdata 32'hA5A5_0001 then 32'd1454761040, each one cycle after read with a 1-cycle readdatavalid; readdata/readdatavalid = 0 during reset.
2. Carry coherence: force counter to 64'h0000_0000_FFFF_FFFF (CLEAR, then wait 2^32−1 cycles or preload via bench hook), read UPTIME_LO, let the counter carry, read UPTIME_HI → LO=32'hFFFF_FFFF, HI=0, not 1.
3. Write 32'h1234_5678 to SCRATCH[0] with byteenable=4'b0101, then read → 32'h0034_0078 with SCRATCH_INIT=0; SCRATCH[1] unchanged; write to word 0 leaves ID unchanged.
4. FREEZE=1 written, read UPTIME_LO twice 10 cycles apart → equal values. Then write CLEAR with FREEZE=1 → next LO read = 0.
5. Simultaneous read+write to SCRATCH[1] = 32'hDEAD_BEEF → no readdatavalid that cycle; the following read returns 32'hDEAD_BEEF. Read of unmapped address 7 → 0 with readdatavalid.
6. Assert reset one cycle after a read strobe → readdatavalid stays 0; counter, shadow and scratch return to reset values.
